// File: rtl/alu_rrr_sequencer.sv
// rtl/alu_rrr_sequencer.sv - fetch/decode/execute control sequencer for 3-register ALU instructions
//
// Purpose: steps a single-bus datapath through T0..T5 for register-register-register ALU
// instructions (ADD/SUB/AND/OR/SHR/SHL). Illegal opcodes or out-of-range register fields
// park the sequencer in HALT until reset.
//
// Ports:
//   Clock, Reset          sole clock; synchronous active-high reset
//   Start, Stop           begin execution from IDLE / halt at the next instruction boundary
//   MemReady              memory read data valid (only honoured when SEQ_MEM_WAIT_EN is defined)
//   IR[DATA_W-1:0]        instruction: opcode on top, then Ra, Rb, Rc fields of REG_W bits
//   PCout..Read           single-bit datapath controls
//   Rin, Rout             one-hot register write / bus-drive enables
//   ALU_op                opcode presented to the ALU (zero outside T4)
//   Busy, Done, Illegal   status
//
// Configuration macro: SEQ_MEM_WAIT_EN - when defined, T1 waits for MemReady.

module alu_rrr_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Stop,
  input  logic                MemReady,
  input  logic [DATA_W-1:0]   IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPC_W-1:0]    ALU_op,
  output logic                Busy,
  output logic                Done,
  output logic                Illegal
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int RA_HI = DATA_W - OPC_W - 1;
  localparam int RB_HI = RA_HI - REG_W;
  localparam int RC_HI = RB_HI - REG_W;
  localparam int LO_HI = RC_HI - REG_W;
  localparam logic [REG_W:0] NREG = (REG_W+1)'(NUM_REGS);

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(5'b00111);
  localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(5'b01000);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   t1_first_q;

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] ra, rb, rc;
  logic             opc_legal;
  logic             regs_ok;
  logic             instr_ok;
  logic             unused_bits;

  assign opc = IR[DATA_W-1 -: OPC_W];
  assign ra  = IR[RA_HI -: REG_W];
  assign rb  = IR[RB_HI -: REG_W];
  assign rc  = IR[RC_HI -: REG_W];

`ifdef SEQ_MEM_WAIT_EN
  assign unused_bits = ^IR[LO_HI:0];
`else
  assign unused_bits = ^{IR[LO_HI:0], MemReady};
`endif

  always_comb begin
    opc_legal = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: opc_legal = 1'b1;
      default:                                       opc_legal = 1'b0;
    endcase
  end

  // Field range only matters when NUM_REGS is not a power of two.
  assign regs_ok  = ({1'b0, ra} < NREG) && ({1'b0, rb} < NREG) && ({1'b0, rc} < NREG);
  assign instr_ok = opc_legal && regs_ok;

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [REG_W-1:0] r);
    reg_sel = NUM_REGS'(1) << r;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      t1_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Marks the entry cycle of T1 so PC update happens once even when T1 stretches.
      t1_first_q <= (state_d == S_T1) && (state_q != S_T1);
    end
  end

  always_comb begin
    state_d = state_q;
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    ALU_op  = '0;
    Busy    = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start && !Stop) state_d = S_T0;
      end
      S_T0: begin
        Busy    = 1'b1;
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Busy    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = t1_first_q;
        Zlowout = t1_first_q;
`ifdef SEQ_MEM_WAIT_EN
        if (MemReady) state_d = S_T2;
`else
        state_d = S_T2;
`endif
      end
      S_T2: begin
        Busy    = 1'b1;
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        Busy = 1'b1;
        if (instr_ok) begin
          Rout    = reg_sel(rb);
          Yin     = 1'b1;
          state_d = S_T4;
        end else begin
          state_d = S_HALT;
        end
      end
      S_T4: begin
        Busy    = 1'b1;
        Rout    = reg_sel(rc);
        Zin     = 1'b1;
        ALU_op  = opc;
        state_d = S_T5;
      end
      S_T5: begin
        Busy    = 1'b1;
        Zlowout = 1'b1;
        Rin     = reg_sel(ra);
        Done    = 1'b1;
        state_d = Stop ? S_IDLE : S_T0;
      end
      S_HALT: begin
        Illegal = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_rrr_sequencer.sv
// tb/tb_alu_rrr_sequencer.sv - self-checking bench for alu_rrr_sequencer

module tb_alu_rrr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, mem_ready;
  logic [31:0] ir, ir12;

  logic        pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, rd;
  logic [15:0] rin, rout;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  logic        b_pc_out, b_zlow_out, b_mdr_out, b_mar_in, b_z_in, b_pc_in, b_mdr_in;
  logic        b_ir_in, b_y_in, b_inc_pc, b_rd;
  logic [11:0] b_rin, b_rout;
  logic [4:0]  b_alu_op;
  logic        b_busy, b_done, b_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rrr_sequencer dut (
    .Clock(clk), .Reset(rst), .Start(start), .Stop(stop), .MemReady(mem_ready), .IR(ir),
    .PCout(pc_out), .Zlowout(zlow_out), .MDRout(mdr_out), .MARin(mar_in), .Zin(z_in),
    .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in), .Yin(y_in), .IncPC(inc_pc), .Read(rd),
    .Rin(rin), .Rout(rout), .ALU_op(alu_op), .Busy(busy), .Done(done), .Illegal(illegal)
  );

  alu_rrr_sequencer #(.NUM_REGS(12)) dut12 (
    .Clock(clk), .Reset(rst), .Start(start), .Stop(stop), .MemReady(mem_ready), .IR(ir12),
    .PCout(b_pc_out), .Zlowout(b_zlow_out), .MDRout(b_mdr_out), .MARin(b_mar_in), .Zin(b_z_in),
    .PCin(b_pc_in), .MDRin(b_mdr_in), .IRin(b_ir_in), .Yin(b_y_in), .IncPC(b_inc_pc), .Read(b_rd),
    .Rin(b_rin), .Rout(b_rout), .ALU_op(b_alu_op), .Busy(b_busy), .Done(b_done), .Illegal(b_illegal)
  );

  // ctl = {PCout,Zlowout,MDRout,MARin,Zin,PCin,MDRin,IRin,Yin,IncPC,Read}
  localparam logic [10:0] C_NONE = 11'b00000000000;
  localparam logic [10:0] C_T0   = 11'b10011000010;
  localparam logic [10:0] C_T1F  = 11'b01000110001;
  localparam logic [10:0] C_T1W  = 11'b00000010001;
  localparam logic [10:0] C_T2   = 11'b00100001000;
  localparam logic [10:0] C_T3   = 11'b00000000100;
  localparam logic [10:0] C_T4   = 11'b00001000000;
  localparam logic [10:0] C_T5   = 11'b01000000000;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        ill;
    logic [15:0] rin;
    logic [15:0] rb;
    logic [15:0] rc;
    logic [4:0]  alu;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Waits to the next falling edge and compares every output of the 16-register DUT.
  task automatic cyc(input string name, input logic [10:0] c, input logic [15:0] r_in,
                     input logic [15:0] r_out, input logic [4:0] alu,
                     input logic bsy, input logic dn, input logic ill);
    logic [63:0] got, exp;
    @(negedge clk);
    got = {13'd0, pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, rd,
           rin, rout, alu_op, busy, done, illegal};
    exp = {13'd0, c, r_in, r_out, alu, bsy, dn, ill};
    chk(name, got, exp);
  endtask

  task automatic idle(input string name);
    cyc(name, C_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic halt(input string name);
    cyc(name, C_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Checks T3..T5 of the AND R1,R2,R3 instruction used by the hand-written sequences.
  task automatic tail_and123(input string name);
    cyc({name, "_t3"}, C_T3, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc({name, "_t4"}, C_T4, 16'h0, 16'h0008, 5'b00101, 1'b1, 1'b0, 1'b0);
    cyc({name, "_t5"}, C_T5, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"and_1_2_3",   32'h28918000,                                  1'b0, 16'h0002, 16'h0004, 16'h0008, 5'b00101};
    vecs[1] = '{"add_0_0_0",   {5'b00011, 4'd0,  4'd0,  4'd0,  14'd0, 1'b0},  1'b0, 16'h0001, 16'h0001, 16'h0001, 5'b00011};
    vecs[2] = '{"sub_15_7_15", {5'b00100, 4'd15, 4'd7,  4'd15, 15'h7fff},     1'b0, 16'h8000, 16'h0080, 16'h8000, 5'b00100};
    vecs[3] = '{"shl_9_9_4",   {5'b01000, 4'd9,  4'd9,  4'd4,  15'd0},        1'b0, 16'h0200, 16'h0200, 16'h0010, 5'b01000};
    vecs[4] = '{"shr_2_14_1",  {5'b00111, 4'd2,  4'd14, 4'd1,  15'd0},        1'b0, 16'h0004, 16'h4000, 16'h0002, 5'b00111};
    vecs[5] = '{"or_5_3_12",   {5'b00110, 4'd5,  4'd3,  4'd12, 15'd0},        1'b0, 16'h0020, 16'h0008, 16'h1000, 5'b00110};
    vecs[6] = '{"ill_11111",   {5'b11111, 4'd1,  4'd2,  4'd3,  15'd0},        1'b1, 16'h0,    16'h0,    16'h0,    5'd0};
    vecs[7] = '{"ill_00010",   {5'b00010, 4'd1,  4'd2,  4'd3,  15'd0},        1'b1, 16'h0,    16'h0,    16'h0,    5'd0};
    vecs[8] = '{"ill_01001",   {5'b01001, 4'd1,  4'd2,  4'd3,  15'd0},        1'b1, 16'h0,    16'h0,    16'h0,    5'd0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mem_ready = 1'b1; ir = 32'h0;
    ir12 = {5'b00011, 4'd11, 4'd10, 4'd1, 15'd0};
    @(negedge clk);
    idle("reset_idle");
    rst = 1'b0;

    // Stop wins over Start in IDLE.
    start = 1'b1; stop = 1'b1;
    idle("stop_wins_a");
    idle("stop_wins_b");
    start = 1'b0; stop = 1'b0;

    for (int i = 0; i < 9; i++) begin
      ir = vecs[i].ir; start = 1'b1;
      cyc({vecs[i].name, "_t0"}, C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      cyc({vecs[i].name, "_t1"}, C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc({vecs[i].name, "_t2"}, C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
      if (vecs[i].ill) begin
        cyc({vecs[i].name, "_t3"}, C_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        halt({vecs[i].name, "_halt"});
        start = 1'b1;
        halt({vecs[i].name, "_halt_start"});
        halt({vecs[i].name, "_halt_hold"});
        start = 1'b0; rst = 1'b1;
        idle({vecs[i].name, "_reset"});
        rst = 1'b0;
      end else begin
        cyc({vecs[i].name, "_t3"}, C_T3, 16'h0, vecs[i].rb, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc({vecs[i].name, "_t4"}, C_T4, 16'h0, vecs[i].rc, vecs[i].alu, 1'b1, 1'b0, 1'b0);
        cyc({vecs[i].name, "_t5"}, C_T5, vecs[i].rin, 16'h0, 5'd0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        idle({vecs[i].name, "_idle"});
        stop = 1'b0;
      end
    end

    // Back-to-back: with Stop low in T5 the next T0 follows immediately.
    ir = 32'h28918000; start = 1'b1;
    cyc("b2b_a_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("b2b_a_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("b2b_a_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tail_and123("b2b_a");
    cyc("b2b_b_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("b2b_b_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("b2b_b_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tail_and123("b2b_b");
    stop = 1'b1;
    idle("b2b_idle");
    stop = 1'b0;

    // Stop raised in T2 with Start held: instruction completes, no new T0.
    start = 1'b1;
    cyc("stop_t2_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("stop_t2_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("stop_t2_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tail_and123("stop_t2");
    idle("stop_t2_idle_a");
    idle("stop_t2_idle_b");
    stop = 1'b0;
    cyc("stop_t2_restart", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0; rst = 1'b1;
    idle("reset_in_t0");
    rst = 1'b0;

    // Reset in T4: next cycle IDLE, no Rin pulse afterwards.
    start = 1'b1;
    cyc("rst_t4_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("rst_t4_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("rst_t4_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("rst_t4_t3", C_T3, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("rst_t4_t4", C_T4, 16'h0, 16'h0008, 5'b00101, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle("rst_t4_idle");
    rst = 1'b0;
    idle("rst_t4_no_rin");

`ifdef SEQ_MEM_WAIT_EN
    // MemReady low for three T1 samples: Read/MDRin held 4 cycles, Done at cycle 9.
    mem_ready = 1'b0; start = 1'b1;
    cyc("wait_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("wait_t1_1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("wait_t1_2", C_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("wait_t1_3", C_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("wait_t1_4", C_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cyc("wait_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tail_and123("wait");
    stop = 1'b1;
    idle("wait_idle");
    stop = 1'b0;

    // Reset while stalled in T1.
    mem_ready = 1'b0; start = 1'b1;
    cyc("wrst_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("wrst_t1_1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("wrst_t1_2", C_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle("wrst_idle");
    rst = 1'b0; mem_ready = 1'b1;
    idle("wrst_stays_idle");
`else
    // MemReady is ignored: T1 lasts one cycle even with MemReady low.
    mem_ready = 1'b0; start = 1'b1;
    cyc("nowait_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("nowait_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("nowait_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tail_and123("nowait");
    stop = 1'b1;
    idle("nowait_idle");
    stop = 1'b0; mem_ready = 1'b1;
`endif

    // 12-register instance: legal high register numbers, then Ra=13 out of range.
    ir12 = {5'b00011, 4'd11, 4'd10, 4'd1, 15'd0};
    start = 1'b1;
    cyc("r12a_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("r12a_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("r12a_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tail_and123("r12a");
    chk("r12a_rin11", {52'd0, b_rin}, {52'd0, 12'h800});
    stop = 1'b1;
    idle("r12a_idle");
    stop = 1'b0;

    ir12 = {5'b00011, 4'd13, 4'd1, 4'd2, 15'd0};
    start = 1'b1;
    cyc("r12b_t0", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("r12b_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("r12b_t2", C_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("r12b_t3", C_T3, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("r12b_t3_quiet", {50'd0, b_rout, b_y_in, b_busy}, {50'd0, 12'h000, 1'b0, 1'b1});
    cyc("r12b_t4", C_T4, 16'h0, 16'h0008, 5'b00101, 1'b1, 1'b0, 1'b0);
    chk("r12b_illegal", {60'd0, b_illegal, b_busy, b_done, |b_rin}, {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    idle("r12b_reset");
    chk("r12b_illegal_cleared", {63'd0, b_illegal}, 64'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
